// File: rtl/cycle_sequencer_pkg.sv
// Shared phase encodings and widths for the instruction-cycle sequencer.
// The CYCLE_EXEC value is consumed directly by the pc block, so keep the encoding stable.
package cycle_sequencer_pkg;

    localparam int CYCLE_WIDTH = 3;
    localparam int CYCLE_SIZE  = CYCLE_WIDTH;
    localparam int TIMER_WIDTH = 8;
    localparam int COUNT_WIDTH = 16;

    typedef enum logic [CYCLE_WIDTH-1:0] {
        CYCLE_IDLE   = 3'd0,
        CYCLE_FETCH  = 3'd1,
        CYCLE_DECODE = 3'd2,
        CYCLE_WAIT   = 3'd3,
        CYCLE_EXEC   = 3'd4,
        CYCLE_HALT   = 3'd5
    } cycle_e;

endpackage

// File: rtl/cycle_sequencer_wait_timer.sv
// Loadable up-counter that measures time spent waiting on the multi-cycle unit.
// tc flags the last permitted WAIT clock.
module wait_timer
    import cycle_sequencer_pkg::*;
#(
    parameter logic [TIMER_WIDTH-1:0] TC_VALUE = 8'd14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    output logic [TIMER_WIDTH-1:0] count,
    output logic                   tc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: FETCH/DECODE/(WAIT)/EXEC with HALT, WAIT timeout fault and retire count.
// Define SINGLE_STEP_EN to add step/dbg_mode ports for one-instruction-per-pulse debug stepping.
//
// state  | meaning
// IDLE   | no instruction in flight, waiting for run (or step in debug mode)
// FETCH  | instruction fetch, one clock
// DECODE | halt_instr / multi_cycle sampled here
// WAIT   | multi-cycle unit busy, timer running
// EXEC   | retire: regwrite_en high, count increments
// HALT   | parked until clear or reset
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int MC_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   clear,
    input  logic                   halt_instr,
    input  logic                   multi_cycle,
    input  logic                   mc_done,
`ifdef SINGLE_STEP_EN
    input  logic                   step,
    input  logic                   dbg_mode,
`endif
    output logic [CYCLE_SIZE-1:0]  cycle,
    output logic                   mc_start,
    output logic                   regwrite_en,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    cycle_e                 state, state_nxt;
    logic                   timeout;
    logic                   go;
    logic                   exec_to_idle;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   timer_tc;
    logic [COUNT_WIDTH-1:0] cnt_q;

`ifdef SINGLE_STEP_EN
    assign go           = dbg_mode ? step : run;
    assign exec_to_idle = dbg_mode | ~run;
`else
    assign go           = run;
    assign exec_to_idle = ~run;
`endif

    wait_timer #(
        .TC_VALUE(TIMER_WIDTH'(MC_TIMEOUT - 1))
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state != CYCLE_WAIT),
        .count (timer),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CYCLE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        if (clear) begin
            state_nxt = CYCLE_IDLE;
        end else begin
            case (state)
                CYCLE_IDLE:   if (go) state_nxt = CYCLE_FETCH;
                CYCLE_FETCH:  state_nxt = CYCLE_DECODE;
                CYCLE_DECODE: begin
                    if (halt_instr)       state_nxt = CYCLE_HALT;
                    else if (multi_cycle) state_nxt = CYCLE_WAIT;
                    else                  state_nxt = CYCLE_EXEC;
                end
                CYCLE_WAIT: begin
                    // mc_done on the terminal clock still completes the instruction
                    if (mc_done) begin
                        state_nxt = CYCLE_EXEC;
                    end else if (timer_tc) begin
                        state_nxt = CYCLE_HALT;
                        timeout   = 1'b1;
                    end
                end
                CYCLE_EXEC:   state_nxt = exec_to_idle ? CYCLE_IDLE : CYCLE_FETCH;
                CYCLE_HALT:   state_nxt = CYCLE_HALT;
                default:      state_nxt = CYCLE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault <= 1'b0;
        end else if (clear) begin
            fault <= 1'b0;
        end else if (timeout) begin
            fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state == CYCLE_EXEC && cnt_q != {COUNT_WIDTH{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cycle       = state;
    assign mc_start    = (state == CYCLE_WAIT) && (timer == '0);
    assign regwrite_en = (state == CYCLE_EXEC);
    assign halted      = (state == CYCLE_HALT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: directed scenarios plus randomized instruction streams
// checked against an instruction-level model of the expected phase trace.
module tb_cycle_sequencer;
    import cycle_sequencer_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        halt_instr = 1'b0;
    logic        multi_cycle = 1'b0;
    logic        mc_done = 1'b0;
    logic        step = 1'b0;
    logic        dbg_mode = 1'b0;
    logic [CYCLE_SIZE-1:0] cycle;
    logic        mc_start, regwrite_en, halted, fault;
    logic [15:0] instr_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_count = '0;
    logic        m_fault = 1'b0;

    cycle_sequencer #(.MC_TIMEOUT(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .halt_instr  (halt_instr),
        .multi_cycle (multi_cycle),
        .mc_done     (mc_done),
`ifdef SINGLE_STEP_EN
        .step        (step),
        .dbg_mode    (dbg_mode),
`endif
        .cycle       (cycle),
        .mc_start    (mc_start),
        .regwrite_en (regwrite_en),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // check every output against the expected phase, then advance one clock
    task automatic tick(input cycle_e exp, input bit mcs);
        chk("cycle", 32'(cycle), 32'(exp));
        chk("regwrite_en", 32'(regwrite_en), 32'(exp == CYCLE_EXEC));
        chk("halted", 32'(halted), 32'(exp == CYCLE_HALT));
        chk("mc_start", 32'(mc_start), 32'(mcs));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("instr_count", 32'(instr_count), 32'(m_count));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic noise();
        halt_instr  = 1'($urandom);
        multi_cycle = 1'($urandom);
        mc_done     = 1'($urandom);
        run         = 1'($urandom);
    endtask

    task automatic to_fetch(input bit stay);
        if (stay) return;
        repeat ($urandom_range(0, 2)) begin
            run = 1'b0;
            tick(CYCLE_IDLE, 1'b0);
        end
        run = 1'b1;
        tick(CYCLE_IDLE, 1'b0);
    endtask

    task automatic end_halt(input bit stay);
        repeat (2) begin
            noise();
            tick(CYCLE_HALT, 1'b0);
        end
        noise();
        clear = 1'b1;
        tick(CYCLE_HALT, 1'b0);
        clear = 1'b0;
        m_fault = 1'b0;
        to_fetch(stay);
    endtask

    // one instruction starting at a FETCH clock; n = WAIT clocks before mc_done
    task automatic run_instr(input bit h, input bit m, input int n, input bit ra, input bit stay);
        noise();
        tick(CYCLE_FETCH, 1'b0);
        noise();
        halt_instr  = h;
        multi_cycle = m;
        tick(CYCLE_DECODE, 1'b0);
        if (h) begin
            end_halt(stay);
            return;
        end
        if (m) begin
            for (int w = 0; w < T; w++) begin
                noise();
                mc_done = (w == n);
                tick(CYCLE_WAIT, w == 0);
                if (w == n) break;
                if (w == T - 1) begin
                    m_fault = 1'b1;
                    end_halt(stay);
                    return;
                end
            end
        end
        noise();
        run = ra;
        tick(CYCLE_EXEC, 1'b0);
        m_count = sat_inc(m_count);
        if (!ra) to_fetch(stay);
    endtask

    initial begin
        @(negedge clk);
        tick(CYCLE_IDLE, 1'b0);
        reset = 1'b1;
        run = 1'b1;
        tick(CYCLE_IDLE, 1'b0);

        repeat (3) run_instr(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("count_after_3", 32'(instr_count), 32'd3);

        run_instr(1'b0, 1'b1, 2, 1'b1, 1'b0);
        run_instr(1'b0, 1'b1, 99, 1'b1, 1'b0);
        run_instr(1'b0, 1'b1, T - 1, 1'b1, 1'b0);
        run_instr(1'b1, 1'b1, 0, 1'b1, 1'b0);

        noise();
        clear = 1'b1;
        tick(CYCLE_FETCH, 1'b0);
        clear = 1'b0;
        to_fetch(1'b0);

        for (int i = 0; i < 40; i++) begin
            run_instr(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                      int'($urandom_range(0, 5)), 1'($urandom), 1'b0);
        end

        noise();
        tick(CYCLE_FETCH, 1'b0);
        noise();
        halt_instr = 1'b0;
        multi_cycle = 1'b1;
        tick(CYCLE_DECODE, 1'b0);
        noise();
        mc_done = 1'b0;
        tick(CYCLE_WAIT, 1'b1);
        mc_done = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_cycle", 32'(cycle), 32'(CYCLE_IDLE));
        chk("rst_mc_start", 32'(mc_start), 32'd0);
        chk("rst_regwrite", 32'(regwrite_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_count = '0;
        m_fault = 1'b0;
        to_fetch(1'b0);

`ifdef SINGLE_STEP_EN
        run_instr(1'b0, 1'b0, 0, 1'b0, 1'b1);
        dbg_mode = 1'b1;
        run = 1'b1;
        halt_instr = 1'b0;
        multi_cycle = 1'b0;
        repeat (2) begin
            step = 1'b0;
            repeat (2) tick(CYCLE_IDLE, 1'b0);
            step = 1'b1;
            tick(CYCLE_IDLE, 1'b0);
            step = 1'b0;
            tick(CYCLE_FETCH, 1'b0);
            tick(CYCLE_DECODE, 1'b0);
            tick(CYCLE_EXEC, 1'b0);
            m_count = sat_inc(m_count);
        end
        tick(CYCLE_IDLE, 1'b0);
        chk("step_count", 32'(instr_count), 32'd3);
        dbg_mode = 1'b0;
        to_fetch(1'b0);
`endif

        run_instr(1'b0, 1'b0, 0, 1'b0, 1'b1);
        run = 1'b0;
        dut.cnt_q = 16'hFFFF;
        m_count = 16'hFFFF;
        to_fetch(1'b0);
        run_instr(1'b0, 1'b0, 0, 1'b1, 1'b0);
        run_instr(1'b0, 1'b1, 1, 1'b1, 1'b0);
        tick(CYCLE_FETCH, 1'b0);
        chk("count_saturated", 32'(instr_count), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
